// File: rtl/ddr_io_stress_engine.sv
// Patterned DDR write-burst engine for I/O bring-up, driving ODDR D0/D1 pins in the PLL clock domain.
// Define DDR_STRESS_CHECK_EN to include the loopback checker, DRAIN state and error status.
module ddr_io_stress_engine #(
  parameter int DQ_WIDTH   = 16,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 4,
  parameter int TURNAROUND = 2,
  parameter int LOOP_LAT   = 3
) (
  input  logic                          SYS_CLK,
  input  logic                          RESET_N,
  input  logic                          pll_locked,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [DQ_WIDTH-1:0]           dq_q0,
  input  logic [DQ_WIDTH-1:0]           dq_q1,
  output logic [DQ_WIDTH-1:0]           dq_d0,
  output logic [DQ_WIDTH-1:0]           dq_d1,
  output logic [DQ_WIDTH/8-1:0]         dq_oe,
  output logic [DQ_WIDTH/8-1:0]         dqs_d0,
  output logic [DQ_WIDTH/8-1:0]         dqs_d1,
  output logic                          ck_d0,
  output logic                          ck_d1,
  output logic                          cke,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [15:0]                   err_count,
  output logic [DQ_WIDTH/8-1:0]         err_lane
);

  localparam int LANES = DQ_WIDTH / 8;
  localparam logic [7:0] BL_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0] LL_LAST = 8'(LOOP_LAT - 1);
  localparam logic [7:0] TA_LAST = 8'(TURNAROUND - 1);
  localparam logic [7:0] NB_LAST = 8'(NUM_BURSTS - 1);
  localparam logic [DQ_WIDTH-1:0] ONE   = DQ_WIDTH'(1);
  localparam logic [DQ_WIDTH-1:0] TWO   = DQ_WIDTH'(2);
  localparam logic [DQ_WIDTH-1:0] ALT_5 = {LANES{8'h55}};
  localparam logic [DQ_WIDTH-1:0] ALT_A = {LANES{8'hAA}};
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {IDLE, PRE, BURST, DRAIN, TURN} state_t;

  state_t              state;
  logic [7:0]          cyc;
  logic [7:0]          burst_cnt;
  logic [1:0]          run_mode;
  logic [DQ_WIDTH-1:0] k_cnt;
  logic [DQ_WIDTH-1:0] walk;
  logic [30:0]         prbs;
  logic [30:0]         prbs_1;
  logic [30:0]         prbs_2;
  logic [DQ_WIDTH-1:0] w0;
  logic [DQ_WIDTH-1:0] w1;
  logic                accept;
  logic                lock_drop;

  function automatic logic [30:0] prbs_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  assign accept    = (state == IDLE) && start && pll_locked;
  assign lock_drop = (state != IDLE) && !pll_locked;

  // Word pair W[k], W[k+1] for the current index; every generator advances in lockstep.
  always_comb begin
    prbs_1 = prbs_step(prbs);
    prbs_2 = prbs_step(prbs_1);
    w0 = '0;
    w1 = '0;
    case (run_mode)
      2'b00: begin
        w0 = k_cnt;
        w1 = k_cnt + ONE;
      end
      2'b01: begin
        w0 = walk;
        w1 = {walk[DQ_WIDTH-2:0], walk[DQ_WIDTH-1]};
      end
      2'b10: begin
        w0 = ALT_5;
        w1 = ALT_A;
      end
      default: begin
        w0 = prbs[DQ_WIDTH-1:0];
        w1 = prbs_1[DQ_WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cyc       <= '0;
      burst_cnt <= '0;
      run_mode  <= '0;
      k_cnt     <= '0;
      walk      <= ONE;
      prbs      <= PRBS_SEED;
      dq_d0     <= '0;
      dq_d1     <= '0;
      dq_oe     <= '0;
      dqs_d0    <= '0;
      dqs_d1    <= '0;
      ck_d0     <= 1'b0;
      ck_d1     <= 1'b0;
      cke       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      ck_d0  <= pll_locked;
      ck_d1  <= 1'b0;
      cke    <= pll_locked;
      done   <= 1'b0;
      dqs_d1 <= '0;
      if (lock_drop) begin
        state  <= IDLE;
        busy   <= 1'b0;
        done   <= 1'b1;
        pass   <= 1'b0;
        dq_oe  <= '0;
        dqs_d0 <= '0;
        dq_d0  <= '0;
        dq_d1  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state     <= PRE;
              busy      <= 1'b1;
              pass      <= 1'b0;
              cyc       <= '0;
              burst_cnt <= '0;
              run_mode  <= mode;
              k_cnt     <= '0;
              walk      <= ONE;
              prbs      <= PRBS_SEED;
              dq_oe     <= '1;
              dqs_d0    <= '0;
              dq_d0     <= '0;
              dq_d1     <= '0;
            end
          end
          PRE, BURST: begin
            if (state == BURST && cyc == BL_LAST) begin
              cyc    <= '0;
              dq_oe  <= '0;
              dqs_d0 <= '0;
              dq_d0  <= '0;
              dq_d1  <= '0;
`ifdef DDR_STRESS_CHECK_EN
              state  <= DRAIN;
`else
              state  <= TURN;
`endif
            end else begin
              state  <= BURST;
              cyc    <= (state == PRE) ? 8'd0 : cyc + 8'd1;
              dq_oe  <= '1;
              dqs_d0 <= '1;
              dq_d0  <= w0;
              dq_d1  <= w1;
              k_cnt  <= k_cnt + TWO;
              walk   <= {walk[DQ_WIDTH-3:0], walk[DQ_WIDTH-1:DQ_WIDTH-2]};
              prbs   <= prbs_2;
            end
          end
`ifdef DDR_STRESS_CHECK_EN
          DRAIN: begin
            if (cyc == LL_LAST) begin
              state <= TURN;
              cyc   <= '0;
            end else begin
              cyc <= cyc + 8'd1;
            end
          end
`endif
          TURN: begin
            if (cyc != TA_LAST) begin
              cyc <= cyc + 8'd1;
            end else if (burst_cnt == NB_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 16'd0);
            end else begin
              state     <= PRE;
              cyc       <= '0;
              burst_cnt <= burst_cnt + 8'd1;
              dq_oe     <= '1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DDR_STRESS_CHECK_EN
  logic [LOOP_LAT-1:0] exp_v;
  logic [DQ_WIDTH-1:0] exp0 [LOOP_LAT];
  logic [DQ_WIDTH-1:0] exp1 [LOOP_LAT];
  logic [LANES-1:0]    lane_mis;

  always_comb begin
    lane_mis = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_mis[j] = |((dq_q0[8*j +: 8] ^ exp0[LOOP_LAT-1][8*j +: 8]) |
                      (dq_q1[8*j +: 8] ^ exp1[LOOP_LAT-1][8*j +: 8]));
    end
  end

  // Expected pipeline is fed from the registered pins, so its tail lines up with loopback data.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      exp_v     <= '0;
      err_count <= '0;
      err_lane  <= '0;
      for (int i = 0; i < LOOP_LAT; i++) begin
        exp0[i] <= '0;
        exp1[i] <= '0;
      end
    end else begin
      exp0[0] <= dq_d0;
      exp1[0] <= dq_d1;
      for (int i = 1; i < LOOP_LAT; i++) begin
        exp0[i] <= exp0[i-1];
        exp1[i] <= exp1[i-1];
      end
      if (lock_drop) begin
        exp_v <= '0;
      end else begin
        exp_v[0] <= dqs_d0[0];
        for (int i = 1; i < LOOP_LAT; i++) exp_v[i] <= exp_v[i-1];
      end
      if (accept) begin
        err_count <= '0;
        err_lane  <= '0;
      end else if (!lock_drop && exp_v[LOOP_LAT-1] && (|lane_mis)) begin
        err_lane <= err_lane | lane_mis;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end
`else
  logic unused_loopback;
  assign unused_loopback = ^{dq_q0, dq_q1};
  assign err_count = '0;
  assign err_lane  = '0;
`endif

endmodule

// File: tb/tb_ddr_io_stress_engine.sv
// Directed bench for ddr_io_stress_engine at default parameters with an ideal 3-cycle loopback.
module tb_ddr_io_stress_engine;

  localparam int W = 16;
`ifdef DDR_STRESS_CHECK_EN
  localparam int RUN_LEN = 56;
  localparam int PER     = 14;
  localparam bit CHK     = 1'b1;
`else
  localparam int RUN_LEN = 44;
  localparam int PER     = 11;
  localparam bit CHK     = 1'b0;
`endif

  logic         SYS_CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         pll_locked = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] dq_q0, dq_q1, dq_d0, dq_d1;
  logic [1:0]   dq_oe, dqs_d0, dqs_d1, err_lane;
  logic         ck_d0, ck_d1, cke, busy, done, pass;
  logic [15:0]  err_count;

  logic [W-1:0] lb0 [3];
  logic [W-1:0] lb1 [3];
  logic [W-1:0] rnd0 = '0;
  logic [W-1:0] rnd1 = '0;
  logic         useRandom = 1'b0;
  logic [W-1:0] stuckMask1 = '0;

  int checkCount = 0;
  int passCount  = 0;
  logic [W-1:0] wq0[$];
  logic [W-1:0] wq1[$];
  int lat, busyCycles, bad;
  logic [1:0] preOe, preDqs, burstDqs, drainOe;

  ddr_io_stress_engine dut (
    .SYS_CLK(SYS_CLK), .RESET_N(RESET_N), .pll_locked(pll_locked), .start(start),
    .mode(mode), .dq_q0(dq_q0), .dq_q1(dq_q1), .dq_d0(dq_d0), .dq_d1(dq_d1),
    .dq_oe(dq_oe), .dqs_d0(dqs_d0), .dqs_d1(dqs_d1), .ck_d0(ck_d0), .ck_d1(ck_d1),
    .cke(cke), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_lane(err_lane)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Ideal loopback: Q in cycle c+3 equals D presented in cycle c.
  always @(posedge SYS_CLK) begin
    lb0[0] <= dq_d0;
    lb0[1] <= lb0[0];
    lb0[2] <= lb0[1];
    lb1[0] <= dq_d1;
    lb1[1] <= lb1[0];
    lb1[2] <= lb1[1];
    rnd0   <= W'($urandom);
    rnd1   <= W'($urandom);
  end

  assign dq_q0 = useRandom ? rnd0 : lb0[2];
  assign dq_q1 = (useRandom ? rnd1 : lb1[2]) & ~stuckMask1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [W-1:0] refWord(input logic [1:0] m, input int k);
    logic [30:0]  s;
    logic [W-1:0] r;
    case (m)
      2'b00: r = W'(k);
      2'b01: r = W'(1) << (k % W);
      2'b10: r = (k % 2 == 0) ? 16'h5555 : 16'hAAAA;
      default: begin
        s = 31'h7FFF_FFFF;
        for (int i = 0; i < k; i++) s = {s[29:0], s[30] ^ s[27]};
        r = s[W-1:0];
      end
    endcase
    return r;
  endfunction

  function automatic int countBad(input logic [1:0] m);
    int n = 0;
    if (wq0.size() != 32 || wq1.size() != 32) return 99;
    for (int c = 0; c < 32; c++) begin
      if (wq0[c] !== refWord(m, 2*c))   n++;
      if (wq1[c] !== refWord(m, 2*c+1)) n++;
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic [1:0] m);
    @(negedge SYS_CLK);
    mode  = m;
    start = 1'b1;
    @(negedge SYS_CLK);
    start = 1'b0;
  endtask

  // Walks the run from the cycle after the accept edge until done, bounded.
  task automatic runCollect(input int pokeAt);
    wq0.delete();
    wq1.delete();
    lat = 0;
    busyCycles = 0;
    while (!done && lat < 400) begin
      if (lat == 0) begin preOe = dq_oe; preDqs = dqs_d0; end
      if (lat == 1) burstDqs = dqs_d0;
      if (lat == 9) drainOe = dq_oe;
      if (busy) busyCycles++;
      if (dqs_d0[0]) begin
        wq0.push_back(dq_d0);
        wq1.push_back(dq_d1);
      end
      start = (lat == pokeAt);
      @(negedge SYS_CLK);
      lat++;
    end
    start = 1'b0;
    checkOutput("run latency", lat, RUN_LEN);
  endtask

  initial begin
    RESET_N    = 1'b0;
    pll_locked = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    checkOutput("reset dq_oe", dq_oe, 0);
    checkOutput("reset ck_d0", ck_d0, 0);
    checkOutput("reset cke", cke, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done/pass", {done, pass}, 0);
    checkOutput("reset err_count", err_count, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    checkOutput("locked ck_d0/ck_d1/cke", {ck_d0, ck_d1, cke}, 3'b101);

    // Counter pattern, with a start pulse mid-run that must be ignored
    applyStimulus(2'b00);
    runCollect(20);
    checkOutput("counter busy cycles", busyCycles, RUN_LEN);
    checkOutput("PRE dq_oe", preOe, 2'b11);
    checkOutput("PRE dqs_d0", preDqs, 2'b00);
    checkOutput("BURST dqs_d0", burstDqs, 2'b11);
    checkOutput("post-burst dq_oe", drainOe, 2'b00);
    checkOutput("counter b1c0", {wq0[0], wq1[0]}, {16'd0, 16'd1});
    checkOutput("counter b1c7", {wq0[7], wq1[7]}, {16'd14, 16'd15});
    checkOutput("counter b2c0", {wq0[8], wq1[8]}, {16'd16, 16'd17});
    bad = countBad(2'b00);
    checkOutput("counter all words", bad, 0);
    checkOutput("counter done", done, 1);
    checkOutput("counter pass", pass, 1);
    checkOutput("counter err_count", err_count, 0);
    checkOutput("counter err_lane", err_lane, 0);
    @(negedge SYS_CLK);
    checkOutput("done one cycle", done, 0);
    checkOutput("pass holds", pass, 1);

    // Alternating with dq_q1[9] stuck low
    stuckMask1 = 16'h0200;
    applyStimulus(2'b10);
    runCollect(-1);
    stuckMask1 = '0;
    checkOutput("stuck err_lane", err_lane, CHK ? 2'b10 : 2'b00);
    checkOutput("stuck err_count", err_count, CHK ? 32 : 0);
    checkOutput("stuck pass", pass, CHK ? 1'b0 : 1'b1);

    // Walking one
    applyStimulus(2'b01);
    runCollect(-1);
    checkOutput("walk b1c0", {wq0[0], wq1[0]}, {16'h0001, 16'h0002});
    checkOutput("walk b1c7 d1", wq1[7], 16'h8000);
    checkOutput("walk b2c0 d0", wq0[8], 16'h0001);
    bad = countBad(2'b01);
    checkOutput("walk all words", bad, 0);
    checkOutput("walk pass", pass, 1);

    // PRBS31
    applyStimulus(2'b11);
    runCollect(-1);
    checkOutput("prbs first d0", wq0[0], 16'hFFFF);
    checkOutput("prbs first d1", wq1[0], 16'hFFFE);
    bad = countBad(2'b11);
    checkOutput("prbs all words", bad, 0);
    checkOutput("prbs pass", pass, 1);

    // Lock loss during burst 2
    applyStimulus(2'b00);
    lat = 0;
    while (lat < PER + 3) begin
      @(negedge SYS_CLK);
      lat++;
    end
    checkOutput("pre-drop busy/oe", {busy, dq_oe}, 3'b111);
    pll_locked = 1'b0;
    @(negedge SYS_CLK);
    checkOutput("drop dq_oe", dq_oe, 0);
    checkOutput("drop busy/done/pass", {busy, done, pass}, 3'b010);
    checkOutput("drop ck_d0/cke", {ck_d0, cke}, 2'b00);
    pll_locked = 1'b1;
    @(negedge SYS_CLK);
    checkOutput("drop done one cycle", done, 0);
    repeat (2) @(negedge SYS_CLK);

    // Reset asserted mid-burst
    applyStimulus(2'b01);
    repeat (4) @(negedge SYS_CLK);
    RESET_N = 1'b0;
    #1;
    checkOutput("async reset oe/dqs", {dq_oe, dqs_d0}, 0);
    checkOutput("async reset dq_d0", dq_d0, 0);
    checkOutput("async reset busy/ck/cke", {busy, ck_d0, cke}, 0);
    @(negedge SYS_CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    applyStimulus(2'b00);
    runCollect(30);
    bad = countBad(2'b00);
    checkOutput("post-reset words", bad, 0);
    checkOutput("post-reset pass", pass, 1);

    // Random loopback data
    useRandom = 1'b1;
    applyStimulus(2'b00);
    runCollect(-1);
    useRandom = 1'b0;
    checkOutput("random pass", pass, !CHK);
    checkOutput("random errors seen", err_count != 16'd0, CHK);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ddr_io_stress_engine.md
# ddr_io_stress_engine

Parametrised, byte-lane-aware pattern engine for DDR I/O bring-up, the next generation of the team's LPDDR3 clocking stress test. It drives the D0/D1 pins of ODDRX1F-style output registers for DQ, DQS, CK and CKE in structured write bursts, with programmable patterns. It then checks loopback data returned through IDDR-style input registers. It sits between a control/status register block and the vendor I/O primitive layer, all in the PLL memory-clock domain.

## Interface
- DQ_WIDTH, 16, DQ bits: 8, 16 or 24; LANES = DQ_WIDTH/8 (localparam)
- BURST_LEN, 8, DDR clock cycles per burst (2 words per cycle), 2..255
- NUM_BURSTS, 4, bursts per run, 1..255
- TURNAROUND, 2, bus-idle cycles after each burst, 1..15
- LOOP_LAT, 3, cycles from D0/D1 presented to matching Q0/Q1 returned, 1..15
- SYS_CLK  in  1  memory clock (PLL output); all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock; engine runs only while high
- start  in  1  run request, sampled in IDLE
- mode  in  2  pattern: 00 counter, 01 walking-one, 10 alternating, 11 PRBS31
- dq_q0, dq_q1  in  DQ_WIDTH  rising/falling loopback words from input DDR registers
- dq_d0, dq_d1  out  DQ_WIDTH  rising/falling words to output DDR registers
- dq_oe  out  LANES  per-lane output enable (1 = drive)
- dqs_d0, dqs_d1  out  LANES  strobe D0/D1 per lane
- ck_d0, ck_d1, cke  out  1  memory clock D0/D1 and clock enable
- busy, done  out  1  run active / one-cycle completion pulse
- pass  out  1  run result, valid from done until next accepted start
- err_count  out  16  mismatching check cycles, saturating
- err_lane  out  LANES  sticky per-lane mismatch flags

## Operation
- FSM: IDLE → PRE (1 cycle) → BURST (BURST_LEN) → DRAIN (LOOP_LAT) → TURN (TURNAROUND) → PRE for the next burst, or IDLE after burst NUM_BURSTS.
- IDLE: start && pll_locked accepted. Clears err_count, err_lane, pass and word index k. start while busy is ignored.
- PRE: dq_oe all 1, dqs_d0/d1 = 0/0, dq_d0/d1 = 0.
- BURST: dq_oe all 1, dqs_d0/d1 = 1/0, dq_d0 = W[k], dq_d1 = W[k+1], then k += 2. k continues across bursts.
- DRAIN, TURN, IDLE: dq_oe = 0, dqs = 0/0, dq_d = 0.
- Patterns, with w = DQ_WIDTH:
  - counter: W[k] = k mod 2^w.
  - walking-one: W[k] = 1 << (k mod w).
  - alternating: even k gives 0x55… and odd k gives 0xAA…
  - PRBS31: s0 = 31'h7FFFFFFF, s(k+1) = {s(k)[29:0], s(k)[30]^s(k)[27]}, W[k] = s(k)[w-1:0]. The engine steps twice per BURST cycle.
- Checker: a valid/expected pipeline of depth LOOP_LAT.
  - Each BURST cycle c is compared LOOP_LAT cycles later: dq_q0 against W[2c], dq_q1 against W[2c+1].
  - Any bit mismatch in lane j sets err_lane[j].
  - Any mismatch in a cycle increments err_count by 1, saturating at 16'hFFFF.
- Completion: done is pulsed on entry to IDLE, and pass = (err_count == 0).
- Clock outputs: ck_d0/ck_d1 = 1/0 and cke = 1 while pll_locked, else 0/0 and 0.
- Lock loss while busy: next cycle enters IDLE with dq_oe = 0, busy = 0, done pulsed, pass = 0. The checker pipeline is flushed.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0; err_count 0; k 0.
- Accepted start at edge n: PRE at n+1, first BURST cycle at n+2.
- Run length from accepted start to done: NUM_BURSTS*(1+BURST_LEN+LOOP_LAT+TURNAROUND) cycles. busy is high for exactly that span.
- Outputs are registered. D0/D1 change only on SYS_CLK rising edges.
- done is exactly 1 cycle. pass, err_count and err_lane hold until the next accepted start.
- Simultaneous mismatch and saturation: err_count stays 16'hFFFF.

## Configuration
- DDR_STRESS_CHECK_EN defined: checker, DRAIN state and error status are present as described.
- Not defined:
  - No checker or expected pipeline; dq_q0/dq_q1 are unused.
  - BURST goes directly to TURN, so run length is NUM_BURSTS*(1+BURST_LEN+TURNAROUND).
  - err_count = 0 and err_lane = 0 constantly.
  - pass = 1 at done, except after lock loss, where pass = 0.

## Test plan
- Defaults, mode 00, ideal loopback with 3-cycle delay → burst 1 d0/d1 = 0/1 … 14/15, burst 2 starts 16/17; done 56 cycles after start; pass = 1, err_count = 0.
- Mode 10, dq_q1[9] stuck 0 → err_lane = 2'b10, err_count = 32, pass = 0.
- Mode 01 → burst 1 cycle 0 d0/d1 = 0x0001/0x0002, cycle 7 d1 = 0x8000; burst 2 cycle 0 d0 = 0x0001. Mode 11 → first d0 = 0xFFFF, and all words match the reference PRBS31 model.
- pll_locked dropped in burst 2 → next cycle dq_oe = 0, busy = 0, done pulse, pass = 0, ck_d0 = 0, cke = 0.
- RESET_N low mid-burst → all outputs 0 immediately. After release, start while busy is ignored and the run count is unaffected.
- Built without DDR_STRESS_CHECK_EN, random dq_q → done at 44 cycles, pass = 1, err_count = 0.
